// File: rtl/tensor_core_cpu.sv
// tensor_core_cpu: single-cycle 16-bit instruction core with eight scalar
// registers and two 3x3 signed 8-bit matrices. Every instruction, including
// the full matrix multiply, commits at the rising edge that samples it.

// Scalar register file R0..R7: one write port, synchronous clear.
module cpu_register_file (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            write_enable,
    input  logic [2:0]      write_address,
    input  logic [7:0]      write_data,
    output logic [7:0][7:0] registers
);
    // Async reset, RESET-opcode clear, else single register write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            registers <= '0;
        else if (clear)
            registers <= '0;
        else if (write_enable)
            registers[write_address] <= write_data;
    end
endmodule

// Tensor register file: registers[m][r][c], flat address m*9 + r*3 + c.
// Bulk port rewrites all of matrix 0; non-bulk port writes one element.
module tensor_core_register_file (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       bulk_write_enable,
    input  logic [8:0][7:0]            bulk_data,
    input  logic                       non_bulk_write_enable,
    input  logic [4:0]                 write_address,
    input  logic [7:0]                 write_data,
    output logic [1:0][2:0][2:0][7:0]  registers
);
    // The two write ports come from different opcodes, so never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registers <= '0;
        end else if (clear) begin
            registers <= '0;
        end else begin
            if (bulk_write_enable)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        registers[0][r][c] <= bulk_data[r*3 + c];
            if (non_bulk_write_enable)
                for (int m = 0; m < 2; m++)
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            if (write_address == 5'(m*9 + r*3 + c))
                                registers[m][r][c] <= write_data;
        end
    end
endmodule

module tensor_core_cpu (
    input  logic              clock_in,
    input  logic              power_on_reset_signal,
    input  logic              shifted_clock_in,
    input  logic [15:0]       current_instruction,
    output logic signed [7:0] cpu_output
);
    localparam int BUS_WIDTH = 7;

    // The phase-shifted clock exists only for port compatibility.
    logic unused_shifted_clock;
    assign unused_shifted_clock = shifted_clock_in;

    logic [3:0]               opcode;
    logic [2:0]               rd;
    logic [BUS_WIDTH:0]       imm8;
    logic signed [BUS_WIDTH:0] rs1_value, rs2_value, rd_value;
    logic [7:0][7:0]          cpu_registers;
    logic [1:0][2:0][2:0][7:0] tensor_registers;
    logic [17:0][7:0]         tensor_flat;
    logic [4:0]               load_ptr;

    logic                     clear;
    logic                     cpu_write_enable;
    logic [2:0]               cpu_write_address;
    logic [7:0]               cpu_write_data;
    logic                     tensor_core_register_file_non_bulk_write_enable;
    logic [4:0]               tensor_write_address;
    logic [7:0]               tensor_write_data;
    logic                     bulk_write_enable;
    logic [8:0][7:0]          bulk_data;
    logic [8:0][7:0]          matmul_result;

    assign opcode    = current_instruction[15:12];
    assign rd        = current_instruction[11:9];
    assign imm8      = current_instruction[7:0];
    assign rs1_value = cpu_registers[current_instruction[8:6]];
    assign rs2_value = cpu_registers[current_instruction[5:3]];
    assign rd_value  = cpu_registers[rd];

    // Packed layout puts registers[m][r][c] at flat index m*9 + r*3 + c.
    assign tensor_flat = tensor_registers;
    assign clear       = (opcode == 4'hD);

    // Addresses 18..31 are outside the file and read as zero.
    function automatic logic [7:0] tensor_read(input logic [4:0] addr,
                                               input logic [17:0][7:0] flat);
        logic [7:0] value;
        value = '0;
        for (int i = 0; i < 18; i++)
            if (addr == 5'(i)) value = flat[i];
        return value;
    endfunction

    // 3x3 product of M0 and M1; every accumulate wraps to 8 bits.
    always_comb begin
        matmul_result = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                logic [7:0] acc;
                acc = '0;
                for (int k = 0; k < 3; k++)
                    acc = acc + tensor_flat[i*3 + k] * tensor_flat[9 + k*3 + j];
                matmul_result[i*3 + j] = acc;
            end
    end

    // Whole-matrix result for TENSOR_CORE_OPERATE; mode 11 is a no-op.
    always_comb begin
        bulk_write_enable = (opcode == 4'h5) && (current_instruction[11:10] != 2'b11);
        bulk_data         = matmul_result;
        for (int i = 0; i < 9; i++)
            case (current_instruction[11:10])
                2'b01:   bulk_data[i] = tensor_flat[i] + tensor_flat[9 + i];
                2'b10:   bulk_data[i] = tensor_flat[i] - tensor_flat[9 + i];
                default: bulk_data[i] = matmul_result[i];
            endcase
    end

    // Instruction decode into scalar and single-element tensor write ports.
    always_comb begin
        cpu_write_enable  = 1'b0;
        cpu_write_address = rd;
        cpu_write_data    = '0;
        tensor_core_register_file_non_bulk_write_enable = 1'b0;
        tensor_write_address = current_instruction[11:7];
        tensor_write_data    = '0;
        case (opcode)
            4'h0: begin cpu_write_enable = 1'b1; cpu_write_data = rs1_value + rs2_value; end
            4'h1: begin cpu_write_enable = 1'b1; cpu_write_data = rs1_value - rs2_value; end
            4'h2: begin cpu_write_enable = 1'b1; cpu_write_data = rs1_value * rs2_value; end
            4'h3: begin cpu_write_enable = 1'b1; cpu_write_data = {7'd0, rs1_value == rs2_value}; end
            4'h4: begin cpu_write_enable = 1'b1; cpu_write_data = {7'd0, rs1_value > rs2_value}; end
            4'h6: begin
                tensor_core_register_file_non_bulk_write_enable = 1'b1;
                tensor_write_address = load_ptr;
                tensor_write_data    = imm8;
            end
            4'h7: begin
                tensor_core_register_file_non_bulk_write_enable = (current_instruction[11:7] < 5'd18);
                tensor_write_data = cpu_registers[current_instruction[6:4]];
            end
            4'h8: begin
                cpu_write_enable = 1'b1;
                cpu_write_data   = tensor_read(current_instruction[8:4], tensor_flat);
            end
            4'hA: begin cpu_write_enable = 1'b1; cpu_write_data = rd_value + imm8; end
            4'hB: begin cpu_write_enable = 1'b1; cpu_write_data = rs1_value; end
            4'hC: begin
                tensor_core_register_file_non_bulk_write_enable = (current_instruction[11:7] < 5'd18);
                tensor_write_data = tensor_read(current_instruction[6:2], tensor_flat);
            end
            default: ;
        endcase
    end

    // Load pointer walks 0..17 and wraps; RESET returns it to 0.
    always_ff @(posedge clock_in or posedge power_on_reset_signal) begin
        if (power_on_reset_signal)
            load_ptr <= '0;
        else if (clear)
            load_ptr <= '0;
        else if (opcode == 4'h6)
            load_ptr <= (load_ptr == 5'd17) ? 5'd0 : load_ptr + 5'd1;
    end

    // Output register only changes on READ_CPU, READ_TENSOR_CORE and RESET.
    always_ff @(posedge clock_in or posedge power_on_reset_signal) begin
        if (power_on_reset_signal)
            cpu_output <= '0;
        else if (clear)
            cpu_output <= '0;
        else if (opcode == 4'hE)
            cpu_output <= rd_value;
        else if (opcode == 4'hF)
            cpu_output <= tensor_read(current_instruction[11:7], tensor_flat);
    end

    cpu_register_file main_cpu_register_file (
        .clock         (clock_in),
        .reset         (power_on_reset_signal),
        .clear         (clear),
        .write_enable  (cpu_write_enable),
        .write_address (cpu_write_address),
        .write_data    (cpu_write_data),
        .registers     (cpu_registers)
    );

    tensor_core_register_file main_tensor_core_register_file (
        .clock                 (clock_in),
        .reset                 (power_on_reset_signal),
        .clear                 (clear),
        .bulk_write_enable     (bulk_write_enable),
        .bulk_data             (bulk_data),
        .non_bulk_write_enable (tensor_core_register_file_non_bulk_write_enable),
        .write_address         (tensor_write_address),
        .write_data            (tensor_write_data),
        .registers             (tensor_registers)
    );
endmodule

// File: tb/tb_tensor_core_cpu.sv
// tb_tensor_core_cpu: directed program from the block's test plan plus
// random instruction streams, checked against an array-based reference model.
module tb_tensor_core_cpu;
    logic              clock_in = 1'b0;
    logic              power_on_reset_signal;
    logic              shifted_clock_in;
    logic [15:0]       current_instruction;
    logic signed [7:0] cpu_output;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic [7:0] mr[8];
    logic [7:0] mt[18];
    int         mptr;
    logic [7:0] mout;

    tensor_core_cpu dut (
        .clock_in              (clock_in),
        .power_on_reset_signal (power_on_reset_signal),
        .shifted_clock_in      (shifted_clock_in),
        .current_instruction   (current_instruction),
        .cpu_output            (cpu_output)
    );

    always #5 clock_in = ~clock_in;
    assign #2 shifted_clock_in = clock_in;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [7:0] tr(input int a);
        return (a < 18) ? mt[a] : 8'd0;
    endfunction

    task automatic model_clear();
        foreach (mr[i]) mr[i] = '0;
        foreach (mt[i]) mt[i] = '0;
        mptr = 0;
        mout = '0;
    endtask

    // Behavioural meaning of one instruction, in plain integer arithmetic.
    task automatic model_step(input logic [15:0] ins);
        int op, rd, rs1, rs2, s, a, b;
        logic [7:0] nt[9];
        logic [7:0] imm;
        op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
        imm = ins[7:0];
        case (op)
            0: mr[rd] = mr[rs1] + mr[rs2];
            1: mr[rd] = mr[rs1] - mr[rs2];
            2: begin s = int'($signed(mr[rs1])) * int'($signed(mr[rs2])); mr[rd] = s[7:0]; end
            3: mr[rd] = (mr[rs1] == mr[rs2]) ? 8'd1 : 8'd0;
            4: mr[rd] = ($signed(mr[rs1]) > $signed(mr[rs2])) ? 8'd1 : 8'd0;
            5: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        s = 0;
                        for (int k = 0; k < 3; k++)
                            s += int'($signed(mt[i*3+k])) * int'($signed(mt[9+k*3+j]));
                        nt[i*3+j] = s[7:0];
                    end
                case (ins[11:10])
                    2'b00: for (int i = 0; i < 9; i++) mt[i] = nt[i];
                    2'b01: for (int i = 0; i < 9; i++) mt[i] = mt[i] + mt[9+i];
                    2'b10: for (int i = 0; i < 9; i++) mt[i] = mt[i] - mt[9+i];
                    default: ;
                endcase
            end
            6: begin mt[mptr] = imm; mptr = (mptr + 1) % 18; end
            7: begin a = ins[11:7]; if (a < 18) mt[a] = mr[ins[6:4]]; end
            8: mr[rd] = tr(int'(ins[8:4]));
            10: mr[rd] = mr[rd] + imm;
            11: mr[rd] = mr[rs1];
            12: begin a = ins[11:7]; b = ins[6:2]; if (a < 18) mt[a] = tr(b); end
            13: model_clear();
            14: mout = mr[rd];
            15: mout = tr(int'(ins[11:7]));
            default: ;
        endcase
    endtask

    // Apply one instruction between edges, then check the output register.
    task automatic exec(input logic [15:0] ins);
        @(negedge clock_in);
        current_instruction = ins;
        @(posedge clock_in);
        #1;
        model_step(ins);
        chk("cpu_output", cpu_output, mout);
    endtask

    task automatic check_state();
        for (int i = 0; i < 8; i++)
            chk("R", dut.main_cpu_register_file.registers[i], mr[i]);
        for (int i = 0; i < 18; i++)
            chk("T", dut.main_tensor_core_register_file.registers[i/9][(i%9)/3][i%3], mt[i]);
    endtask

    task automatic read_t(input int a, input logic [7:0] exp);
        logic [15:0] ins;
        ins = 16'hF000 | 16'(a << 7);
        exec(ins);
        chk("read_t", cpu_output, exp);
    endtask

    // Asynchronous reset pulse wholly between two rising edges.
    task automatic async_reset();
        @(negedge clock_in);
        current_instruction = 16'h9000;
        #2 power_on_reset_signal = 1'b1;
        #1;
        model_clear();
        chk("async_rst_out", cpu_output, 8'd0);
        check_state();
        power_on_reset_signal = 1'b0;
    endtask

    initial begin
        logic [15:0] ins;
        model_clear();
        power_on_reset_signal = 1'b1;
        current_instruction   = 16'h6055;
        repeat (3) @(posedge clock_in);
        #1;
        chk("reset_out", cpu_output, 8'd0);
        check_state();
        @(negedge clock_in);
        current_instruction   = 16'h9000;
        power_on_reset_signal = 1'b0;

        // Scalar ALU
        exec(16'hA205); exec(16'hA4FD);
        exec(16'h0650); exec(16'hE600); chk("add", cpu_output, 8'd2);
        exec(16'h1650); exec(16'hE600); chk("sub", cpu_output, 8'd8);
        exec(16'h4650); exec(16'hE600); chk("grt", cpu_output, 8'd1);
        exec(16'h3650); exec(16'hE600); chk("eql", cpu_output, 8'd0);
        exec(16'hA264 & 16'hFF00 | 16'h0064);
        exec(16'hA000 | 16'h0200); // R1 += 0
        exec(16'hB240); // R1 = R1 (move)
        // MUL wrap: R1=100, R2=3
        exec(16'hD000); exec(16'hA264); exec(16'hA403);
        exec(16'h2650); exec(16'hE600); chk("mul_wrap", cpu_output, 8'd44);

        // Tensor load + matmul
        exec(16'hD000);
        for (int i = 1; i <= 9; i++) exec(16'h6000 | 16'(i));
        for (int i = 0; i < 9; i++) exec(16'h6002);
        exec(16'h5000);
        for (int i = 0; i < 9; i++) read_t(i, (i < 3) ? 8'd12 : (i < 6) ? 8'd30 : 8'd48);
        read_t(9, 8'd2); read_t(17, 8'd2); read_t(25, 8'd0);
        check_state();

        // Matmul overflow
        exec(16'hD000);
        for (int i = 0; i < 18; i++) exec(16'h600A);
        exec(16'h5000);
        for (int i = 0; i < 9; i++) read_t(i, 8'd44);

        // Moves and out-of-range write
        exec(16'hD000); exec(16'hA205);
        exec(16'h7890); exec(16'hC044); exec(16'h8E00);
        exec(16'hEE00); chk("moves", cpu_output, 8'd5);
        exec(16'h7A10);
        check_state();

        // RESET opcode then async reset, next load lands in T0
        exec(16'h6033); exec(16'h6044);
        exec(16'hD000); chk("op_reset_out", cpu_output, 8'd0);
        check_state();
        exec(16'h6011); exec(16'hA27F);
        async_reset();
        exec(16'h6007);
        chk("load_after_rst", dut.main_tensor_core_register_file.registers[0][0][0], 8'd7);
        check_state();

        // Random instruction stream
        for (int n = 0; n < 2000; n++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hD && $urandom_range(0, 7) != 0) ins[15:12] = 4'h6;
            exec(ins);
            if (n % 16 == 15) check_state();
            if (n % 500 == 499) async_reset();
        end
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
